nn_seq_driver: RTL
==================

# nn_seq_driver

Initiator-side sequencer for the `nn` datapath. It accepts one operand pair at a time over a valid/ready input port. For each pair it hard-resets `nn`, pulses `enable`, and waits for `nn` to reach IDLE. It then captures `final_output`/`total_ovf`/`total_zero` and returns a result over a valid/ready output port, keeping running sample and overflow counters.

## Interface
- `SIZE`, 32, operand/result width
- `RST_CYCLES`, 2, cycles `nn_resetn` is held low per sample (≥1)
- `CNT_W`, 16, width of `sample_cnt`/`ovf_cnt`
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `NN_SEQ_TIMEOUT_EN`)

- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  sequencer can accept a pair
- `in_data_1`, `in_data_2`  in  SIZE  operands
- `nn_input_1`, `nn_input_2`  out  SIZE  registered operands to `nn`
- `nn_enable`  out  1  start pulse to `nn`
- `nn_resetn`  out  1  per-sample reset to `nn`
- `nn_state`  in  3  `nn` FSM state (3'b000 DEACTIVATED, 3'b110 IDLE)
- `nn_final_output`  in  SIZE
- `nn_total_ovf`, `nn_total_zero`  in  1
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumer ready
- `res_data`  out  SIZE  result
- `res_ovf`, `res_zero`, `res_timeout`  out  1  result flags
- `sample_cnt`, `ovf_cnt`  out  CNT_W  completed samples / overflowed samples

## Operation
- FSM states: S_IDLE, S_RST, S_ARM, S_FIRE, S_WAIT, S_SETTLE, S_RESULT.
- S_IDLE: `in_ready`=1, `nn_resetn`=1.
  - On `in_valid & in_ready`, latch `in_data_*` into `nn_input_*` and go to S_RST.
- S_RST: `nn_resetn`=0 for exactly `RST_CYCLES` cycles, then go to S_ARM.
- S_ARM: `nn_resetn`=1 for one cycle, then go to S_FIRE.
- S_FIRE: `nn_enable`=1 until `nn_state`≠3'b000 is sampled; `nn_enable` deasserts on that edge; go to S_WAIT.
- S_WAIT: when `nn_state`==3'b110 is sampled, go to S_SETTLE.
- S_SETTLE: one cycle, then capture results:
  - If `nn_total_ovf`=1: `res_data`=all ones, `res_ovf`=1, `res_zero`=0.
  - Otherwise: `res_data`=`nn_final_output`, `res_ovf`=0, `res_zero`=`nn_total_zero`.
  - `sample_cnt`+1, and `ovf_cnt`+1 when overflowed. Both counters wrap modulo 2^CNT_W.
  - Go to S_RESULT.
- S_RESULT: `res_valid`=1, and `res_*` hold stable until `res_ready`. On `res_valid & res_ready`, go to S_IDLE.
- `in_ready`=0 in every state except S_IDLE. `in_valid` outside S_IDLE is ignored.
- `nn_input_*` hold the latched operands until the next accept.

## Timing
- Reset (async assert) values:
  - state S_IDLE; `nn_resetn`=0.
  - `in_ready`, `nn_enable`, `res_valid`, all `res_*` flags = 0.
  - `res_data`, `nn_input_*`, counters = 0.
- After reset release, `nn_resetn` and `in_ready` go to 1 on the first clock edge.
- Accept at edge k:
  - `nn_resetn` low from k to k+RST_CYCLES.
  - High at k+RST_CYCLES.
  - `nn_enable` rises at k+RST_CYCLES+1.
- `res_valid` rises 2 edges after IDLE is first sampled (S_SETTLE, then capture).
- `res_ready` already high when `res_valid` rises: transfer completes on that edge. `in_ready` rises on the same edge. There is no same-cycle bypass.
- Every output is a register; there is no combinational in→out path.
- `resetn` asserted mid-sample: immediate return to S_IDLE with reset values. The in-flight result is lost and the counters clear.

## Configuration
- `NN_SEQ_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in S_FIRE+S_WAIT.
  - Reaching `TIMEOUT` forces S_RESULT with `res_timeout`=1, `res_data`=all ones, `res_ovf`=0, `res_zero`=0.
  - `sample_cnt` increments and `ovf_cnt` does not.
  - `nn_enable` drops on the expiry edge.
- `NN_SEQ_TIMEOUT_EN` undefined:
  - No watchdog logic; `res_timeout` is tied 0 and `TIMEOUT` is unused.
  - The FSM waits in S_FIRE/S_WAIT indefinitely.

## Test plan
- Reset checks:
  - Assert `resetn`=0 mid-S_WAIT → all outputs reach reset values without a clock edge.
  - After release: `in_ready`=1 one edge later; counters = 0.
- Nominal sample:
  - Drive pair (5,−3) with `res_ready`=1 → `nn_resetn` low exactly 2 cycles, `nn_enable` a single contiguous pulse ending when `nn_state`≠0.
  - `res_data` equals the `nn_model` result; `sample_cnt`=1.
- Overflow: drive pair (0x7FFFFFF0, 0x7FFFFFF0), with `nn` reporting `total_ovf` → `res_data`=0xFFFFFFFF, `res_ovf`=1, `ovf_cnt`=1.
- Backpressure:
  - Hold `res_ready`=0 for 10 cycles → `res_valid` and `res_*` stay stable; `in_ready`=0 throughout, and an `in_valid` pulse is ignored.
  - Release → exactly one transfer.
- Back-to-back and counter wrap: 100 random pairs with `CNT_W`=4 → `sample_cnt` ends at 100 mod 16 = 4; every result matches `nn_model`.
- Timeout (macro on, `TIMEOUT`=8): stub `nn_state` stuck at 3'b000 → result at S_FIRE+8 with `res_timeout`=1, `res_data`=0xFFFFFFFF.
- Timeout (macro off): same stub → no result after 1000 cycles.

Source files
------------

// File: rtl/nn_seq_driver_if.sv
// Operand/result handshake bundle between nn_seq_driver and its source/sink.
// Valid/ready: a beat transfers on a rising clk edge where valid and ready are both 1;
// the sender keeps valid and payload stable until that edge, ready may change at any time.
interface nn_seq_driver_if #(
    parameter int SIZE = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data_1;
    logic [SIZE-1:0] in_data_2;
    logic            res_valid;
    logic            res_ready;
    logic [SIZE-1:0] res_data;
    logic            res_ovf;
    logic            res_zero;
    logic            res_timeout;

    modport master (
        output in_valid, in_data_1, in_data_2, res_ready,
        input  in_ready, res_valid, res_data, res_ovf, res_zero, res_timeout
    );

    modport slave (
        input  in_valid, in_data_1, in_data_2, res_ready,
        output in_ready, res_valid, res_data, res_ovf, res_zero, res_timeout
    );
endinterface

// File: rtl/nn_seq_driver.sv
// Runs one operand pair at a time through the nn datapath and returns a flagged result.
// Define NN_SEQ_TIMEOUT_EN to build the S_FIRE/S_WAIT watchdog (limit TIMEOUT cycles).
module nn_seq_driver #(
    parameter int SIZE       = 32,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             resetn,
    nn_seq_driver_if.slave   bus,
    output logic [SIZE-1:0]  nn_input_1,
    output logic [SIZE-1:0]  nn_input_2,
    output logic             nn_enable,
    output logic             nn_resetn,
    input  logic [2:0]       nn_state,
    input  logic [SIZE-1:0]  nn_final_output,
    input  logic             nn_total_ovf,
    input  logic             nn_total_zero,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [2:0]       dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_ARM    = 3'd2,
        S_FIRE   = 3'd3,
        S_WAIT   = 3'd4,
        S_SETTLE = 3'd5,
        S_RESULT = 3'd6
    } state_t;

    localparam logic [2:0] NN_DEACTIVATED = 3'b000;
    localparam logic [2:0] NN_IDLE        = 3'b110;

    localparam int               RST_W    = $clog2(RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("nn_seq_driver: RST_CYCLES and TIMEOUT must be at least 1");
    end

    state_t           state;
    state_t           state_next;
    logic [RST_W-1:0] rst_cnt;
    logic             accept;
    logic             capture;

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            expire;

    // Counts every cycle spent waiting on nn; cleared whenever we are elsewhere.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
        end else if (state == S_FIRE || state == S_WAIT) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_cnt <= '0;
        end else if (state == S_RST) begin
            rst_cnt <= rst_cnt + RST_W'(1);
        end else begin
            rst_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
        expire     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    accept     = 1'b1;
                    state_next = S_RST;
                end
            end
            S_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_next = S_ARM;
                end
            end
            S_ARM:  state_next = S_FIRE;
            S_FIRE: begin
                if (nn_state != NN_DEACTIVATED) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (nn_state == NN_IDLE) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                capture    = 1'b1;
                state_next = S_RESULT;
            end
            S_RESULT: begin
                if (bus.res_valid && bus.res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
`ifdef NN_SEQ_TIMEOUT_EN
        // Expiry overrides whatever nn reports on the same edge.
        if ((state == S_FIRE || state == S_WAIT) && wd_cnt == WD_LAST) begin
            expire     = 1'b1;
            state_next = S_RESULT;
        end
`endif
    end

    // Control outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.in_ready  <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_ovf   <= 1'b0;
            bus.res_zero  <= 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
            bus.res_timeout <= 1'b0;
`endif
            nn_resetn     <= 1'b0;
            nn_enable     <= 1'b0;
            nn_input_1    <= '0;
            nn_input_2    <= '0;
            sample_cnt    <= '0;
            ovf_cnt       <= '0;
        end else begin
            bus.in_ready  <= (state_next == S_IDLE);
            bus.res_valid <= (state_next == S_RESULT);
            nn_resetn     <= (state_next != S_RST);
            nn_enable     <= (state_next == S_FIRE);
            if (accept) begin
                nn_input_1 <= bus.in_data_1;
                nn_input_2 <= bus.in_data_2;
            end
            if (capture) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                if (nn_total_ovf) begin
                    bus.res_data <= '1;
                    bus.res_ovf  <= 1'b1;
                    bus.res_zero <= 1'b0;
                    ovf_cnt      <= ovf_cnt + CNT_W'(1);
                end else begin
                    bus.res_data <= nn_final_output;
                    bus.res_ovf  <= 1'b0;
                    bus.res_zero <= nn_total_zero;
                end
`ifdef NN_SEQ_TIMEOUT_EN
                bus.res_timeout <= 1'b0;
`endif
            end
`ifdef NN_SEQ_TIMEOUT_EN
            if (expire) begin
                sample_cnt      <= sample_cnt + CNT_W'(1);
                bus.res_data    <= '1;
                bus.res_ovf     <= 1'b0;
                bus.res_zero    <= 1'b0;
                bus.res_timeout <= 1'b1;
            end
`endif
        end
    end

`ifndef NN_SEQ_TIMEOUT_EN
    assign bus.res_timeout = 1'b0;
`endif

    assign dbg_state = state;
endmodule
